// File: rtl/code_comparator_if.sv
`default_nettype none
// ============================================================================
//  Module      : code_comparator_if
//  Description : Request/result bundle between the lock controller and the
//                code comparator. The controller side uses the master
//                modport and the comparator uses the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface code_comparator_if #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4,
    parameter int CNT_W   = 3,
    parameter int FAIL_W  = 2
);
    logic                        compare_start;
    logic [DIGITS*DIGIT_W-1:0]   entered_code;
    logic [CNT_W-1:0]            digit_count;
    logic [DIGITS*DIGIT_W-1:0]   stored_code;
    logic                        stored_valid;
    logic                        clear_lockout;
    logic                        comparator_done;
    logic                        match;
    logic                        busy;
    logic [FAIL_W-1:0]           fail_count;
    logic                        lockout;

    modport master (
        output compare_start,
        output entered_code,
        output digit_count,
        output stored_code,
        output stored_valid,
        output clear_lockout,
        input  comparator_done,
        input  match,
        input  busy,
        input  fail_count,
        input  lockout
    );

    modport slave (
        input  compare_start,
        input  entered_code,
        input  digit_count,
        input  stored_code,
        input  stored_valid,
        input  clear_lockout,
        output comparator_done,
        output match,
        output busy,
        output fail_count,
        output lockout
    );
endinterface
`default_nettype wire

// File: rtl/code_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : code_comparator
//  Description : Constant-time digit-by-digit comparison of the keypad code
//                against the stored password, with a consecutive-failure
//                counter and a sticky lockout flag cleared only by an admin.
//  Revision    : 1.0 - initial release
// ============================================================================
module code_comparator #(
    parameter int DIGITS    = 4,
    parameter int DIGIT_W   = 4,
    parameter int CNT_W     = 3,
    parameter int MAX_FAILS = 3,
    parameter int FAIL_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    code_comparator_if.slave  bus
);

    localparam int CODE_W = DIGITS * DIGIT_W;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [IDX_W-1:0]  C_LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0]  C_FULL_CNT  = CNT_W'(DIGITS);
    localparam logic [FAIL_W-1:0] C_MAX_FAILS = FAIL_W'(MAX_FAILS);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CHECK   = 2'd1;
    localparam logic [1:0] S_COMPARE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // Registered state
    logic [1:0]        r_state_q;
    logic [IDX_W-1:0]  r_idx_q;
    logic              r_flag_q;
    logic              r_match_q;
    logic [FAIL_W-1:0] r_fail_q;
    logic              r_lock_q;
    logic [CODE_W-1:0] r_entered_q;
    logic [CODE_W-1:0] r_stored_q;
    logic [CNT_W-1:0]  r_count_q;
    logic              r_valid_q;

    // Next-state values
    logic [1:0]        w_state_d;
    logic [IDX_W-1:0]  w_idx_d;
    logic              w_flag_d;
    logic              w_match_d;
    logic [FAIL_W-1:0] w_fail_d;
    logic              w_lock_d;
    logic [CODE_W-1:0] w_entered_d;
    logic [CODE_W-1:0] w_stored_d;
    logic [CNT_W-1:0]  w_count_d;
    logic              w_valid_d;

    // Digit currently under comparison
    logic [DIGIT_W-1:0] w_ent_digit;
    logic [DIGIT_W-1:0] w_sto_digit;
    logic               w_digit_ne;
    logic               w_reject;

    // Select snapshot digit idx from both codes
    always_comb begin
        w_ent_digit = '0;
        w_sto_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx_q == IDX_W'(i)) begin
                w_ent_digit = r_entered_q[i*DIGIT_W +: DIGIT_W];
                w_sto_digit = r_stored_q[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    assign w_digit_ne = (w_ent_digit != w_sto_digit);

    // A request is refused outright when locked, unset, or incompletely entered
    assign w_reject = r_lock_q || !r_valid_q || (r_count_q != C_FULL_CNT);

    // Comparison FSM: snapshot, pre-check, full-length compare, report
    always_comb begin
        w_state_d   = r_state_q;
        w_idx_d     = r_idx_q;
        w_flag_d    = r_flag_q;
        w_match_d   = r_match_q;
        w_entered_d = r_entered_q;
        w_stored_d  = r_stored_q;
        w_count_d   = r_count_q;
        w_valid_d   = r_valid_q;

        case (r_state_q)
            S_IDLE: begin
                if (bus.compare_start) begin
                    w_entered_d = bus.entered_code;
                    w_stored_d  = bus.stored_code;
                    w_count_d   = bus.digit_count;
                    w_valid_d   = bus.stored_valid;
                    w_match_d   = 1'b0;
                    w_state_d   = S_CHECK;
                end
            end

            S_CHECK: begin
                if (w_reject) begin
                    w_flag_d  = 1'b1;
                    w_match_d = 1'b0;
                    w_state_d = S_DONE;
                end else begin
                    w_idx_d   = '0;
                    w_flag_d  = 1'b0;
                    w_state_d = S_COMPARE;
                end
            end

            S_COMPARE: begin
                // Mismatch is sticky; every digit is visited regardless so
                // the completion time never leaks which digit was wrong.
                w_flag_d = r_flag_q | w_digit_ne;
                if (r_idx_q == C_LAST_IDX) begin
                    w_match_d = !(r_flag_q | w_digit_ne);
                    w_state_d = S_DONE;
                end else begin
                    w_idx_d = r_idx_q + IDX_W'(1);
                end
            end

            S_DONE: begin
                w_state_d = S_IDLE;
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // Failure counter and lockout, updated as DONE is left; admin clear wins
    always_comb begin
        w_fail_d = r_fail_q;
        w_lock_d = r_lock_q;

        if (r_state_q == S_DONE) begin
            if (r_match_q) begin
                w_fail_d = '0;
            end else if (!r_lock_q) begin
                if (r_fail_q != C_MAX_FAILS) begin
                    w_fail_d = r_fail_q + FAIL_W'(1);
                end
                if (w_fail_d == C_MAX_FAILS) begin
                    w_lock_d = 1'b1;
                end
            end
        end

        if (bus.clear_lockout) begin
            w_fail_d = '0;
            w_lock_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q   <= S_IDLE;
            r_idx_q     <= '0;
            r_flag_q    <= 1'b0;
            r_match_q   <= 1'b0;
            r_fail_q    <= '0;
            r_lock_q    <= 1'b0;
            r_entered_q <= '0;
            r_stored_q  <= '0;
            r_count_q   <= '0;
            r_valid_q   <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_idx_q     <= w_idx_d;
            r_flag_q    <= w_flag_d;
            r_match_q   <= w_match_d;
            r_fail_q    <= w_fail_d;
            r_lock_q    <= w_lock_d;
            r_entered_q <= w_entered_d;
            r_stored_q  <= w_stored_d;
            r_count_q   <= w_count_d;
            r_valid_q   <= w_valid_d;
        end
    end

    assign bus.comparator_done = (r_state_q == S_DONE);
    assign bus.busy            = (r_state_q != S_IDLE);
    assign bus.match           = r_match_q;
    assign bus.fail_count      = r_fail_q;
    assign bus.lockout         = r_lock_q;

endmodule
`default_nettype wire

// File: tb/tb_code_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_code_comparator
//  Description : Self-checking bench for code_comparator: directed scenarios
//                followed by random BCD requests against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_code_comparator;

    logic clk;
    logic reset;

    code_comparator_if #(.DIGITS(4), .DIGIT_W(4), .CNT_W(3), .FAIL_W(2)) bus ();

    code_comparator #(
        .DIGITS(4), .DIGIT_W(4), .CNT_W(3), .MAX_FAILS(3), .FAIL_W(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: consecutive failures and lockout
    int m_fail = 0;
    bit m_lock = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request; expectations come from the behavioural rules only
    task automatic run_req(input logic [15:0] e, input logic [15:0] s,
                           input logic [2:0] cnt, input logic v,
                           input bit hold, input bit chained, input bit disturb);
        bit rej;
        bit exp_m;
        int lat;
        rej   = m_lock || !v || (cnt != 3'd4);
        exp_m = !rej && (e == s);
        lat   = rej ? 2 : 6;
        if (!chained) @(negedge clk);
        bus.entered_code  = e;
        bus.stored_code   = s;
        bus.digit_count   = cnt;
        bus.stored_valid  = v;
        bus.compare_start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) bus.compare_start = 1'b0;
            chk("busy", bus.busy, 1);
            chk("done", bus.comparator_done, (k == lat));
            if (k == lat) chk("match", bus.match, exp_m);
            if (disturb && k == 3) begin
                bus.entered_code  = ~e;
                bus.stored_code   = e ^ 16'h0F0F;
                bus.compare_start = 1'b1;
            end
            if (disturb && k == 4) bus.compare_start = 1'b0;
        end
        if (exp_m) begin
            m_fail = 0;
        end else if (!m_lock) begin
            if (m_fail < 3) m_fail++;
            if (m_fail == 3) m_lock = 1'b1;
        end
        @(negedge clk);
        chk("done_after", bus.comparator_done, 0);
        chk("busy_after", bus.busy, 0);
        chk("match_hold", bus.match, exp_m);
        chk("fail_count", bus.fail_count, m_fail);
        chk("lockout", bus.lockout, m_lock);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.clear_lockout = 1'b1;
        @(negedge clk);
        bus.clear_lockout = 1'b0;
        m_fail = 0;
        m_lock = 1'b0;
        chk("clr_fail", bus.fail_count, 0);
        chk("clr_lock", bus.lockout, 0);
    endtask

    // Safety net against a stuck simulation
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] s;
        logic [15:0] e;
        logic [2:0]  cnt;
        logic        v;
        int          d;
        logic [3:0]  dig;

        reset             = 1'b0;
        bus.compare_start = 1'b0;
        bus.entered_code  = '0;
        bus.stored_code   = '0;
        bus.digit_count   = '0;
        bus.stored_valid  = 1'b0;
        bus.clear_lockout = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_done", bus.comparator_done, 0);
        chk("rst_match", bus.match, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_fail", bus.fail_count, 0);
        chk("rst_lock", bus.lockout, 0);
        reset = 1'b1;

        // Directed scenarios
        run_req(16'h1234, 16'h1234, 3'd4, 1'b1, 0, 0, 0);  // correct
        run_req(16'h5234, 16'h1234, 3'd4, 1'b1, 0, 0, 0);  // wrong last digit
        run_req(16'h1234, 16'h1234, 3'd3, 1'b1, 0, 0, 0);  // short entry
        run_req(16'h1234, 16'h1234, 3'd4, 1'b1, 0, 0, 0);  // resets count
        run_req(16'h1234, 16'h1234, 3'd4, 1'b0, 0, 0, 0);  // no password saved
        run_req(16'h1234, 16'h1234, 3'd4, 1'b1, 0, 0, 0);
        run_req(16'h1235, 16'h1234, 3'd4, 1'b1, 0, 0, 0);  // three mismatches
        run_req(16'h9999, 16'h1234, 3'd4, 1'b1, 0, 0, 0);
        run_req(16'h1234, 16'h0000, 3'd4, 1'b1, 0, 0, 0);
        run_req(16'h1234, 16'h1234, 3'd4, 1'b1, 0, 0, 0);  // locked: rejected
        pulse_clear();
        run_req(16'h1234, 16'h1234, 3'd4, 1'b1, 0, 0, 0);  // unlocked again
        run_req(16'h4321, 16'h4321, 3'd4, 1'b1, 0, 0, 1);  // snapshot + ignored start
        run_req(16'h0001, 16'h1000, 3'd4, 1'b1, 0, 0, 1);
        run_req(16'h7777, 16'h7777, 3'd4, 1'b1, 1, 0, 0);  // held start re-triggers
        run_req(16'h7777, 16'h7777, 3'd4, 1'b1, 0, 1, 0);

        // Reset during COMPARE
        run_req(16'h1111, 16'h2222, 3'd4, 1'b1, 0, 0, 0);
        @(negedge clk);
        bus.entered_code  = 16'h8642;
        bus.stored_code   = 16'h8642;
        bus.digit_count   = 3'd4;
        bus.stored_valid  = 1'b1;
        bus.compare_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.compare_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        m_fail = 0;
        m_lock = 1'b0;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.comparator_done, 0);
        chk("mid_rst_match", bus.match, 0);
        chk("mid_rst_fail", bus.fail_count, 0);
        chk("mid_rst_lock", bus.lockout, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("no_done_after_rst", bus.comparator_done, 0);
        end
        run_req(16'h8642, 16'h8642, 3'd4, 1'b1, 0, 0, 0);

        // Random requests
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 4; i++) s[i*4 +: 4] = 4'($urandom_range(0, 9));
            e = s;
            if ($urandom_range(0, 2) == 0) begin
                d   = $urandom_range(0, 3);
                dig = s[d*4 +: 4];
                e[d*4 +: 4] = 4'((int'(dig) + 1 + $urandom_range(0, 8)) % 10);
            end
            cnt = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'd4;
            v   = ($urandom_range(0, 7) != 0);
            run_req(e, s, cnt, v, 0, 0, 0);
            if (m_lock && ($urandom_range(0, 1) == 1)) pulse_clear();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
